// File: rtl/iterative_multiplier_pkg.sv
// Shared encodings for the iterative multiplier: operation types and FSM states.
`default_nettype none
package iterative_multiplier_pkg;

  localparam logic [2:0] MUL_TYPE_MUL   = 3'b000;
  localparam logic [2:0] MUL_TYPE_MLA   = 3'b001;
  localparam logic [2:0] MUL_TYPE_SMULL = 3'b100;
  localparam logic [2:0] MUL_TYPE_SMLAL = 3'b101;
  localparam logic [2:0] MUL_TYPE_UMULL = 3'b110;
  localparam logic [2:0] MUL_TYPE_UMLAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic type_is_long(input logic [2:0] t);
    return (t == MUL_TYPE_SMULL) || (t == MUL_TYPE_SMLAL) ||
           (t == MUL_TYPE_UMULL) || (t == MUL_TYPE_UMLAL);
  endfunction

  function automatic logic type_is_signed(input logic [2:0] t);
    return (t == MUL_TYPE_MUL) || (t == MUL_TYPE_MLA) ||
           (t == MUL_TYPE_SMULL) || (t == MUL_TYPE_SMLAL);
  endfunction

  function automatic logic type_accumulates(input logic [2:0] t);
    return (t == MUL_TYPE_MLA) || (t == MUL_TYPE_SMLAL) || (t == MUL_TYPE_UMLAL);
  endfunction

  function automatic logic type_is_illegal(input logic [2:0] t);
    return !(type_is_long(t) || (t == MUL_TYPE_MUL) || (t == MUL_TYPE_MLA));
  endfunction

endpackage
`default_nettype wire

// File: rtl/iterative_multiplier_mul_step.sv
// One radix step: sum_o = acc_i + mcand_i * digit_i, built as a shift-add over the digit bits.
`default_nettype none
module mul_step
  import iterative_multiplier_pkg::*;
#(
  parameter int ACC_W      = 64,
  parameter int RADIX_BITS = 2
) (
  input  logic [ACC_W-1:0]      acc_i,
  input  logic [ACC_W-1:0]      mcand_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  output logic [ACC_W-1:0]      sum_o
);

  always_comb begin
    sum_o = acc_i;
    for (int k = 0; k < RADIX_BITS; k++) begin
      if (digit_i[k]) begin
        sum_o = sum_o + (mcand_i << k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iterative_multiplier.sv
// Multi-cycle MUL/MLA/SMULL/SMLAL/UMULL/UMLAL unit with valid/ready on both sides.
// Define EARLY_TERMINATION_EN to leave RUN once the remaining multiplier bits are zero.
`default_nettype none
module iterative_multiplier
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2:0]         type_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  input  logic [WIDTH-1:0]   d_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               n_o,
  output logic               z_o
);

  localparam int CYCLES = WIDTH / RADIX_BITS;
  localparam int ACC_W  = 2 * WIDTH;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_radix
    $error("iterative_multiplier: WIDTH must be a multiple of RADIX_BITS");
  end

  state_e             state_q, state_d;
  logic [2:0]         type_q, type_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               n_q, n_d;
  logic               z_q, z_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [ACC_W-1:0]   step_sum;
  logic [WIDTH-1:0]   mplier_shift;
  logic               run_last;
  logic [ACC_W-1:0]   fix_prod, fix_term, fix_sum;
  logic [ACC_W-1:0]   fix_result;
  logic               fix_n, fix_z;

  // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1) for the most-negative input.
  always_comb begin
    a_neg = type_is_signed(type_i) && a_i[WIDTH-1];
    b_neg = type_is_signed(type_i) && b_i[WIDTH-1];
    a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag = b_neg ? (~b_i + 1'b1) : b_i;
  end

  mul_step #(
    .ACC_W      (ACC_W),
    .RADIX_BITS (RADIX_BITS)
  ) u_mul_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (mplier_q[RADIX_BITS-1:0]),
    .sum_o   (step_sum)
  );

  assign mplier_shift = mplier_q >> RADIX_BITS;

  always_comb begin
`ifdef EARLY_TERMINATION_EN
    run_last = (cnt_q == CNT_W'(CYCLES - 1)) || (mplier_shift == '0);
`else
    run_last = (cnt_q == CNT_W'(CYCLES - 1));
`endif
  end

  always_comb begin
    fix_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    fix_term = '0;
    if (type_q == MUL_TYPE_MLA) begin
      fix_term = {{WIDTH{1'b0}}, c_q};
    end else if (type_accumulates(type_q)) begin
      fix_term = {c_q, d_q};
    end
    fix_sum = fix_prod + fix_term;

    if (type_is_illegal(type_q)) begin
      fix_result = '0;
      fix_n      = 1'b0;
      fix_z      = 1'b1;
    end else if (type_is_long(type_q)) begin
      fix_result = fix_sum;
      fix_n      = fix_sum[ACC_W-1];
      fix_z      = (fix_sum == '0);
    end else begin
      fix_result = {{WIDTH{1'b0}}, fix_sum[WIDTH-1:0]};
      fix_n      = fix_sum[WIDTH-1];
      fix_z      = (fix_sum[WIDTH-1:0] == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    c_d      = c_q;
    d_d      = d_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d  = ST_RUN;
          type_d   = type_i;
          c_d      = c_i;
          d_d      = d_i;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          cnt_d    = '0;
        end
      end
      ST_RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (run_last) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        result_d = fix_result;
        n_d      = fix_n;
        z_d      = fix_z;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      c_q      <= '0;
      d_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      c_q      <= c_d;
      d_q      <= d_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;
  assign n_o      = n_q;
  assign z_o      = z_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier at WIDTH=32, RADIX_BITS=2.
`default_nettype none
module tb_iterative_multiplier;

  localparam int W = 32;
  localparam int R = 2;
  localparam logic [2:0] T_MUL = 3'b000, T_MLA = 3'b001, T_SMULL = 3'b100,
                         T_SMLAL = 3'b101, T_UMULL = 3'b110, T_UMLAL = 3'b111;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, ready_o, valid_o, ready_i;
  logic [2:0]    type_i;
  logic [W-1:0]  a_i, b_i, c_i, d_i;
  logic [2*W-1:0] result_o;
  logic          n_o, z_o;

  iterative_multiplier #(.WIDTH(W), .RADIX_BITS(R)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .type_i   (type_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .c_i      (c_i),
    .d_i      (d_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .n_o      (n_o),
    .z_o      (z_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [63:0]  res;
    logic         n;
    logic         z;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", nm, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [2:0] t, input logic [W-1:0] b);
`ifdef EARLY_TERMINATION_EN
    logic [W-1:0] mag;
    int bits, steps;
    logic sgn;
    sgn = (t == T_MUL) || (t == T_MLA) || (t == T_SMULL) || (t == T_SMLAL);
    mag = (sgn && b[W-1]) ? (~b + 1'b1) : b;
    bits = 0;
    for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
    steps = (bits + R - 1) / R;
    if (steps < 1) steps = 1;
    return steps + 1;
`else
    return W / R + 1;
`endif
  endfunction

  task automatic issue(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, output int acc_cyc);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!ready_o && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    type_i  = t;
    a_i     = a;
    b_i     = b;
    c_i     = c;
    d_i     = d;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [2:0] t, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [63:0] res, input logic n, input logic z);
    exp_t e;
    int   ac;
    issue(t, a, b, c, d, ac);
    e.name    = nm;
    e.res     = res;
    e.n       = n;
    e.z       = z;
    e.acc_cyc = ac;
    e.lat     = exp_latency(t, b);
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || !ready_o) && budget < 300) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on each rising valid_o, then checks the output holds while valid_o stays high.
  initial begin
    exp_t cur;
    logic prev_v;
    prev_v = 1'b0;
    cur.name = "none"; cur.res = '0; cur.n = 1'b0; cur.z = 1'b0; cur.acc_cyc = 0; cur.lat = 0;
    forever begin
      @(posedge clk);
      #1;
      if (valid_o && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=result 0x%h expected=no result", result_o);
        end else begin
          cur = sb.pop_front();
          chk({cur.name, "_result"}, result_o, cur.res);
          chk({cur.name, "_n"}, 64'(n_o), 64'(cur.n));
          chk({cur.name, "_z"}, 64'(z_o), 64'(cur.z));
          chk({cur.name, "_latency"}, 64'(cyc - cur.acc_cyc), 64'(cur.lat));
        end
      end else if (valid_o) begin
        chk({cur.name, "_hold"}, {result_o[61:0], n_o, z_o}, {cur.res[61:0], cur.n, cur.z});
      end
      prev_v = valid_o;
    end
  end

  initial begin
    int ac;
    int budget;
    reset   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    type_i  = '0;
    a_i = '0; b_i = '0; c_i = '0; d_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_nz", 64'({n_o, z_o}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("t1_mul", T_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42, 1'b0, 1'b0);
    do_op("t2_smull", T_SMULL, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0,
          64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0);
    do_op("t3_umlal", T_UMLAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,
          64'hFFFF_FFFE_0000_0002, 1'b1, 1'b0);
    do_op("t3_mla", T_MLA, 32'd3, 32'd4, 32'hFFFF_FFF4, 32'd0, 64'd0, 1'b0, 1'b1);
    do_op("t6_smull_min", T_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
          64'h4000_0000_0000_0000, 1'b0, 1'b0);
    do_op("t6_illegal", 3'b010, 32'd5, 32'd5, 32'd0, 32'd0, 64'd0, 1'b0, 1'b1);
    do_op("smlal", T_SMLAL, 32'd2, 32'hFFFF_FFFD, 32'd0, 32'h0000_0010, 64'd10, 1'b0, 1'b0);
    do_op("umull", T_UMULL, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0);
    do_op("mul_neg", T_MUL, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFF1, 1'b1, 1'b0);
    drain();

    // T4: consumer stalls; busy-time requests must be ignored.
    ready_i = 1'b0;
    do_op("t4_stall", T_UMULL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0,
          64'h0000_0001_0000_0000, 1'b0, 1'b0);
    budget = 0;
    while (!valid_o && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("t4_valid_seen", 64'(valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      type_i = T_MUL; a_i = 32'd9; b_i = 32'd9; valid_i = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_ready_low", 64'(ready_o), 64'd0);
      chk("t4_valid_held", 64'(valid_o), 64'd1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_back_idle", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_no_accept", 64'(ready_o), 64'd1);

    // T5: reset mid-RUN discards the operation.
    issue(T_MUL, 32'd9, 32'd9, 32'd0, 32'd0, ac);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(ready_o), 64'd1);
    chk("t5_rst_valid", 64'(valid_o), 64'd0);
    chk("t5_rst_result", result_o, 64'd0);
    chk("t5_rst_nz", 64'({n_o, z_o}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("t5_mul", T_MUL, 32'd5, 32'd5, 32'd0, 32'd0, 64'd25, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
